// File: rtl/period_meter_pkg.sv
// Shared types and event decoding for the multi-channel period meter.
package period_meter_pkg;

   typedef enum logic [1:0] {
      EM_RISE = 2'b00,
      EM_FALL = 2'b01,
      EM_ANY  = 2'b10,
      EM_HIGH = 2'b11
   } edge_mode_t;

   // Returns {arm, capture} for the selected mode given the synchronised level and its delayed copy.
   function automatic logic [1:0] decode_event(input edge_mode_t mode, input logic cur, input logic prev);
      logic       rise;
      logic       fall;
      logic [1:0] ev;
      rise = cur & ~prev;
      fall = ~cur & prev;
      case (mode)
         EM_RISE: ev = {rise, rise};
         EM_FALL: ev = {fall, fall};
         EM_ANY:  ev = {rise | fall, rise | fall};
         default: ev = {rise, fall};
      endcase
      return ev;
   endfunction

endpackage

// File: rtl/period_meter_mc_if.sv
// Shared read port of the period meter: one-cycle-latency request/response.
interface period_meter_mc_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 20
);
   localparam int RD_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic            rd_en;
   logic [RD_W-1:0] rd_ch;
   logic            rd_valid;
   logic [CNT_W-1:0] rd_data;
   logic            rd_sat;
   logic            rd_missed;

   modport master (output rd_en, rd_ch, input rd_valid, rd_data, rd_sat, rd_missed);
   modport slave  (input rd_en, rd_ch, output rd_valid, rd_data, rd_sat, rd_missed);
endinterface

// File: rtl/period_meter_channel.sv
// One measurement channel: synchroniser, event decode, saturating interval counter and capture flags.
module period_meter_channel
   import period_meter_pkg::*;
#(
   parameter int CNT_W       = 20,
   parameter int CNT_MAX     = 100000,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             as_reset_n,
   input  logic             i_sig,
   input  edge_mode_t       i_mode,
   input  logic             i_enable,
   input  logic             i_restart,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_result,
   output logic             o_sat,
   output logic             o_new,
   output logic             o_missed
);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(CNT_MAX);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;
   edge_mode_t             r_mode_prev;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_armed;
   logic [CNT_W-1:0]       r_result;
   logic                   r_sat;
   logic                   r_new;
   logic                   r_missed;

   logic [1:0]       w_ev;
   logic             w_arm;
   logic             w_cap;
   logic             w_mode_chg;
   logic             w_do_cap;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_ev       = decode_event(i_mode, r_sync[SYNC_STAGES-1], r_dly);
   assign w_arm      = w_ev[1];
   assign w_cap      = w_ev[0];
   assign w_mode_chg = (i_mode != r_mode_prev);
   // An enable rise counts as disarmed even if the armed flag has not yet dropped.
   assign w_do_cap   = i_enable & ~w_mode_chg & ~i_restart & r_armed & w_cap;
   assign w_cnt_inc  = (r_cnt == CNT_LIM) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge as_reset_n) begin
      if (!as_reset_n) begin
         r_sync      <= '0;
         r_dly       <= 1'b0;
         r_mode_prev <= EM_RISE;
         r_cnt       <= '0;
         r_armed     <= 1'b0;
         r_result    <= '0;
         r_sat       <= 1'b0;
         r_new       <= 1'b0;
         r_missed    <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], i_sig};
         r_dly       <= r_sync[SYNC_STAGES-1];
         r_mode_prev <= i_mode;

         if (!i_enable || w_mode_chg) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
         end else if (w_do_cap || w_arm) begin
            r_cnt   <= CNT_W'(1);
            r_armed <= 1'b1;
         end else begin
            r_cnt <= w_cnt_inc;
         end

         // A capture coinciding with a read keeps the fresh flag and starts a clean missed state.
         if (w_do_cap) begin
            r_result <= r_cnt;
            r_sat    <= (r_cnt == CNT_LIM);
            r_new    <= 1'b1;
            r_missed <= i_clr ? 1'b0 : (r_missed | r_new);
         end else if (i_clr) begin
            r_new    <= 1'b0;
            r_missed <= 1'b0;
         end
      end
   end

   assign o_result = r_result;
   assign o_sat    = r_sat;
   assign o_new    = r_new;
   assign o_missed = r_missed;

endmodule

// File: rtl/period_meter_mc.sv
// Multi-channel edge-to-edge interval meter: per-channel capture units behind a shared registered read port.
module period_meter_mc
   import period_meter_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 20,
   parameter int CNT_MAX     = 100000,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              as_reset_n,
   input  logic              i_enable,
   input  logic [N_CH-1:0]   i_signal_in,
   input  logic [2*N_CH-1:0] i_edge_mode,
   period_meter_mc_if.slave  rd,
   output logic [N_CH-1:0]   o_new_meas
);
   localparam int RD_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             r_en_prev;
   logic             r_rd_valid;
   logic [CNT_W-1:0] r_rd_data;
   logic             r_rd_sat;
   logic             r_rd_missed;

   logic             w_en_rise;
   logic             w_ch_ok;
   logic [CNT_W-1:0] w_result [N_CH];
   logic [N_CH-1:0]  w_sat;
   logic [N_CH-1:0]  w_missed;
   logic [N_CH-1:0]  w_clr;

   assign w_en_rise = i_enable & ~r_en_prev;
   assign w_ch_ok   = ({1'b0, rd.rd_ch} < (RD_W+1)'(N_CH));

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign w_clr[g] = rd.rd_en & w_ch_ok & (rd.rd_ch == RD_W'(g));

      period_meter_channel #(
         .CNT_W       (CNT_W),
         .CNT_MAX     (CNT_MAX),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk        (clk),
         .as_reset_n (as_reset_n),
         .i_sig      (i_signal_in[g]),
         .i_mode     (edge_mode_t'(i_edge_mode[2*g+1:2*g])),
         .i_enable   (i_enable),
         .i_restart  (w_en_rise),
         .i_clr      (w_clr[g]),
         .o_result   (w_result[g]),
         .o_sat      (w_sat[g]),
         .o_new      (o_new_meas[g]),
         .o_missed   (w_missed[g])
      );
   end

   // Read data reflects channel state before any same-cycle capture; it holds between requests.
   always_ff @(posedge clk or negedge as_reset_n) begin
      if (!as_reset_n) begin
         r_en_prev   <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_rd_sat    <= 1'b0;
         r_rd_missed <= 1'b0;
      end else begin
         r_en_prev  <= i_enable;
         r_rd_valid <= rd.rd_en;
         if (rd.rd_en) begin
            if (w_ch_ok) begin
               r_rd_data   <= w_result[rd.rd_ch];
               r_rd_sat    <= w_sat[rd.rd_ch];
               r_rd_missed <= w_missed[rd.rd_ch];
            end else begin
               r_rd_data   <= '0;
               r_rd_sat    <= 1'b0;
               r_rd_missed <= 1'b0;
            end
         end
      end
   end

   assign rd.rd_valid  = r_rd_valid;
   assign rd.rd_data   = r_rd_data;
   assign rd.rd_sat    = r_rd_sat;
   assign rd.rd_missed = r_rd_missed;

endmodule

// File: tb/tb_period_meter_mc.sv
// Directed bench for period_meter_mc: main 4-channel instance plus a 3-channel instance for out-of-range reads.
module tb_period_meter_mc;
   import period_meter_pkg::*;

   logic       clk = 1'b0;
   logic       as_reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] sig = '0;
   logic [7:0] edge_mode = '0;
   logic [3:0] new_meas;
   logic [2:0] new_meas2;
   int         vectors = 0;
   int         fails = 0;

   period_meter_mc_if #(.N_CH(4), .CNT_W(20)) rd ();
   period_meter_mc_if #(.N_CH(3), .CNT_W(20)) rd2 ();

   period_meter_mc #(.N_CH(4), .CNT_W(20), .CNT_MAX(50), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .as_reset_n  (as_reset_n),
      .i_enable    (enable),
      .i_signal_in (sig),
      .i_edge_mode (edge_mode),
      .rd          (rd.slave),
      .o_new_meas  (new_meas)
   );

   period_meter_mc #(.N_CH(3), .CNT_W(20), .CNT_MAX(50), .SYNC_STAGES(2)) dut2 (
      .clk         (clk),
      .as_reset_n  (as_reset_n),
      .i_enable    (enable),
      .i_signal_in ({2'b00, sig[0]}),
      .i_edge_mode (6'b000000),
      .rd          (rd2.slave),
      .o_new_meas  (new_meas2)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wave(input int ch, input int hi, input int lo);
      sig[ch] = 1'b1;
      tick(hi);
      sig[ch] = 1'b0;
      tick(lo);
   endtask

   task automatic do_read(input logic [1:0] ch);
      rd.rd_en = 1'b1;
      rd.rd_ch = ch;
      tick(1);
      rd.rd_en = 1'b0;
   endtask

   initial begin
      rd.rd_en  = 1'b0;
      rd.rd_ch  = '0;
      rd2.rd_en = 1'b0;
      rd2.rd_ch = '0;
      tick(3);
      chk("rst_valid", 32'(rd.rd_valid), 0);
      chk("rst_data", 32'(rd.rd_data), 0);
      chk("rst_new", 32'(new_meas), 0);
      as_reset_n = 1'b1;
      enable = 1'b1;
      tick(3);

      // Rising mode, period 10 on ch0
      wave(0, 5, 5);
      chk("t1_arm_only", 32'(new_meas[0]), 0);
      sig[0] = 1'b1;
      tick(3);
      chk("t1_new", 32'(new_meas[0]), 1);
      tick(2);
      sig[0] = 1'b0;
      tick(4);
      do_read(0);
      chk("t1_valid", 32'(rd.rd_valid), 1);
      chk("t1_data", 32'(rd.rd_data), 10);
      chk("t1_sat", 32'(rd.rd_sat), 0);
      chk("t1_missed0", 32'(rd.rd_missed), 0);
      chk("t1_clr", 32'(new_meas[0]), 0);
      wave(0, 5, 5);
      wave(0, 5, 5);
      do_read(0);
      chk("t1_data2", 32'(rd.rd_data), 10);
      chk("t1_missed1", 32'(rd.rd_missed), 1);
      tick(1);
      chk("t1_valid_lo", 32'(rd.rd_valid), 0);
      chk("t1_data_hold", 32'(rd.rd_data), 10);

      // High-pulse mode on ch1, then switch to any-edge
      edge_mode[3:2] = 2'b11;
      tick(2);
      wave(1, 3, 7);
      do_read(1);
      chk("t2_pulse", 32'(rd.rd_data), 3);
      edge_mode[3:2] = 2'b10;
      tick(2);
      sig[1] = 1'b1;
      tick(3);
      chk("t2_arm_only", 32'(new_meas[1]), 0);
      sig[1] = 1'b0;
      tick(3);
      chk("t2_new", 32'(new_meas[1]), 1);
      tick(3);
      do_read(1);
      chk("t2_hi", 32'(rd.rd_data), 3);
      sig[1] = 1'b1;
      tick(3);
      sig[1] = 1'b0;
      do_read(1);
      chk("t2_lo", 32'(rd.rd_data), 7);
      tick(5);
      do_read(1);
      chk("t2_hi2", 32'(rd.rd_data), 3);

      // Saturation on ch2 (CNT_MAX=50)
      wave(2, 40, 40);
      sig[2] = 1'b1;
      tick(3);
      do_read(2);
      chk("t3_sat_data", 32'(rd.rd_data), 50);
      chk("t3_sat_flag", 32'(rd.rd_sat), 1);
      tick(6);
      sig[2] = 1'b0;
      tick(10);
      sig[2] = 1'b1;
      tick(3);
      do_read(2);
      chk("t3_data", 32'(rd.rd_data), 20);
      chk("t3_sat_clr", 32'(rd.rd_sat), 0);
      sig[2] = 1'b0;

      // Read colliding with capture on ch3
      wave(3, 5, 5);
      wave(3, 5, 10);
      sig[3] = 1'b1;
      tick(2);
      rd.rd_en = 1'b1;
      rd.rd_ch = 2'd3;
      tick(1);
      rd.rd_en = 1'b0;
      chk("t4_old", 32'(rd.rd_data), 10);
      chk("t4_new_kept", 32'(new_meas[3]), 1);
      do_read(3);
      chk("t4_fresh", 32'(rd.rd_data), 15);
      chk("t4_missed", 32'(rd.rd_missed), 0);
      chk("t4_clr", 32'(new_meas[3]), 0);
      sig[3] = 1'b0;

      // Asynchronous reset mid-period
      sig[0] = 1'b1;
      tick(3);
      chk("t5_pre_new", 32'(new_meas[0]), 1);
      tick(2);
      as_reset_n = 1'b0;
      #1;
      chk("t5_rst_data", 32'(rd.rd_data), 0);
      chk("t5_rst_new", 32'(new_meas), 0);
      sig[0] = 1'b0;
      tick(2);
      as_reset_n = 1'b1;
      edge_mode = '0;
      tick(2);
      wave(0, 5, 5);
      chk("t5_arm_only", 32'(new_meas[0]), 0);
      sig[0] = 1'b1;
      tick(3);
      chk("t5_new", 32'(new_meas[0]), 1);
      tick(2);
      sig[0] = 1'b0;
      tick(3);

      // Enable low retains results; enable rise re-arms
      enable = 1'b0;
      tick(3);
      chk("t5_retain", 32'(new_meas[0]), 1);
      do_read(0);
      chk("t5_retain_data", 32'(rd.rd_data), 10);
      wave(0, 5, 5);
      chk("t5_dis_new", 32'(new_meas[0]), 0);
      enable = 1'b1;
      tick(2);
      wave(0, 5, 5);
      chk("t5_en_arm", 32'(new_meas[0]), 0);
      sig[0] = 1'b1;
      tick(3);
      chk("t5_en_new", 32'(new_meas[0]), 1);
      do_read(0);
      chk("t5_en_data", 32'(rd.rd_data), 10);
      sig[0] = 1'b0;

      // Out-of-range channel on the 3-channel instance
      rd2.rd_en = 1'b1;
      rd2.rd_ch = 2'd0;
      tick(1);
      rd2.rd_ch = 2'd3;
      chk("t5_d2_data", 32'(rd2.rd_data), 10);
      chk("t5_d2_missed", 32'(rd2.rd_missed), 1);
      chk("t5_d2_clr", 32'(new_meas2), 0);
      tick(1);
      rd2.rd_en = 1'b0;
      chk("t5_oor_valid", 32'(rd2.rd_valid), 1);
      chk("t5_oor_data", 32'(rd2.rd_data), 0);
      chk("t5_oor_missed", 32'(rd2.rd_missed), 0);
      chk("t5_oor_sat", 32'(rd2.rd_sat), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
